// File: rtl/fpu_pipe_ctrl.sv
// Handshake and occupancy controller for a three-stage FP pipeline (issue, mul/div, add, normalize).
// Stage 1 holds a divide for DIV_CYCLES cycles; the later stages advance under elastic backpressure.
module fpu_pipe_ctrl #(
  parameter int unsigned DIV_CYCLES = 14
) (
  input  logic       clock,
  input  logic       clr,
  input  logic       in_valid,
  input  logic       in_div,
  output logic       in_ready,
  input  logic       out_ready,
  input  logic       flush,
  output logic       e1,
  output logic       e2,
  output logic       e3,
  output logic       v1,
  output logic       v2,
  output logic       v3,
  output logic       out_valid,
  output logic       div_busy,
  output logic [1:0] occ
);

  localparam logic [3:0] DivLoad = 4'(DIV_CYCLES - 1);

  logic       r_v1;
  logic       r_v2;
  logic       r_v3;
  logic [3:0] r_cnt;

  logic w_live;
  logic w_s1Done;
  logic w_busy;
  logic w_rdy3;
  logic w_rdy2;

  assign w_live   = !clr && !flush;
  assign w_s1Done = r_v1 && (r_cnt == 4'd0);
  assign w_busy   = r_v1 && (r_cnt != 4'd0);
  assign w_rdy3   = !r_v3 || out_ready;
  assign w_rdy2   = !r_v2 || w_rdy3;

  // out_ready reaches in_ready combinationally so a full pipe can still accept an op
  // in the same cycle the result is consumed.
  assign in_ready = w_live && (!r_v1 || (w_s1Done && w_rdy2));
  assign e1       = in_valid && in_ready;
  assign e2       = w_live && w_s1Done && w_rdy2;
  assign e3       = w_live && r_v2 && w_rdy3;

  assign v1 = r_v1;
  assign v2 = r_v2;
  assign v3 = r_v3;

  // Status outputs read as idle for the whole clr cycle, not only after its edge.
  assign out_valid = !clr && r_v3;
  assign div_busy  = !clr && w_busy;
  assign occ       = clr ? 2'd0 : ({1'b0, r_v1} + {1'b0, r_v2} + {1'b0, r_v3});

  always_ff @(posedge clock) begin
    if (clr || flush) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_cnt <= 4'd0;
    end else begin
      r_v1 <= e1 || (r_v1 && !e2);
      r_v2 <= e2 || (r_v2 && !e3);
      r_v3 <= e3 || (r_v3 && !out_ready);
      if (e1) begin
        r_cnt <= in_div ? DivLoad : 4'd0;
      end else if (w_busy) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_pipe_ctrl.sv
// Self-checking bench for fpu_pipe_ctrl: per-scenario tasks plus a queue of expected result cycles.
module tb_fpu_pipe_ctrl;

  localparam int DIV = 14;

  logic       clock = 1'b0;
  logic       clr, in_valid, in_div, out_ready, flush;
  logic       in_ready, e1, e2, e3, v1, v2, v3, out_valid, div_busy;
  logic [1:0] occ;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int expQ[$];

  fpu_pipe_ctrl #(.DIV_CYCLES(DIV)) dut (
    .clock(clock), .clr(clr), .in_valid(in_valid), .in_div(in_div), .in_ready(in_ready),
    .out_ready(out_ready), .flush(flush), .e1(e1), .e2(e2), .e3(e3), .v1(v1), .v2(v2),
    .v3(v3), .out_valid(out_valid), .div_busy(div_busy), .occ(occ)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic test_reset();
    clr = 1; flush = 1; in_valid = 1; in_div = 1; out_ready = 1;
    @(posedge clock); #1;
    @(negedge clock);
    total++;
    if ({in_ready, e1, e2, e3, out_valid, div_busy} !== 6'b0 || occ !== 2'd0) begin
      bad++;
      $display("[TB] FAIL reset_hold: got rdy/e1/e2/e3/ov/busy=%b occ=%0d, want 000000 occ=0",
               {in_ready, e1, e2, e3, out_valid, div_busy}, occ);
    end
    @(posedge clock); #1;
    clr = 0; flush = 0; in_valid = 0; in_div = 0;
    @(negedge clock);
    total++;
    if (in_ready !== 1'b1 || {v1, v2, v3} !== 3'b0 || occ !== 2'd0) begin
      bad++;
      $display("[TB] FAIL reset_release: got rdy=%b v=%b occ=%0d, want rdy=1 v=000 occ=0",
               in_ready, {v1, v2, v3}, occ);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_single_mul();
    int t0, expv;
    int expOcc[6] = '{0, 1, 1, 1, 0, 0};
    t0 = cyc;
    for (int k = 0; k < 6; k++) begin
      in_valid = (k == 0); in_div = 0; out_ready = 1;
      if (k == 0) expQ.push_back(t0 + 3);
      @(negedge clock);
      total++;
      if ({e1, e2, e3, out_valid} !== {k == 0, k == 1, k == 2, k == 3} || occ !== 2'(expOcc[k])) begin
        bad++;
        $display("[TB] FAIL single_mul k=%0d: got e1e2e3ov=%b occ=%0d, want %b occ=%0d",
                 k, {e1, e2, e3, out_valid}, occ, {k == 0, k == 1, k == 2, k == 3}, expOcc[k]);
      end
      if (out_valid && out_ready) begin
        total++;
        expv = (expQ.size() > 0) ? expQ.pop_front() : -1;
        if (cyc !== expv) begin
          bad++;
          $display("[TB] FAIL sb_single_mul: result at cycle %0d, expected cycle %0d", cyc, expv);
        end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_back_to_back();
    int t0, expv;
    int peak = 0;
    t0 = cyc;
    for (int k = 0; k < 9; k++) begin
      in_valid = (k < 4); in_div = 0; out_ready = 1;
      if (k < 4) expQ.push_back(t0 + k + 3);
      @(negedge clock);
      if (int'(occ) > peak) peak = int'(occ);
      total++;
      if ((k < 4 && in_ready !== 1'b1) || out_valid !== (k >= 3 && k <= 6)) begin
        bad++;
        $display("[TB] FAIL b2b k=%0d: got rdy=%b ov=%b, want rdy=1(k<4) ov=%b",
                 k, in_ready, out_valid, (k >= 3 && k <= 6));
      end
      if (out_valid && out_ready) begin
        total++;
        expv = (expQ.size() > 0) ? expQ.pop_front() : -1;
        if (cyc !== expv) begin
          bad++;
          $display("[TB] FAIL sb_b2b: result at cycle %0d, expected cycle %0d", cyc, expv);
        end
      end
      @(posedge clock); #1;
    end
    total++;
    if (peak !== 3) begin
      bad++;
      $display("[TB] FAIL b2b_peak_occ: got %0d, want 3", peak);
    end
  endtask

  task automatic test_div_then_mul();
    int t0, expv;
    t0 = cyc;
    for (int k = 0; k < 20; k++) begin
      in_valid = (k <= DIV); in_div = (k == 0); out_ready = 1;
      if (k == 0) expQ.push_back(t0 + DIV + 2);
      if (k == DIV) expQ.push_back(t0 + DIV + 3);
      @(negedge clock);
      if (k == 0) begin
        total++;
        if (in_ready !== 1'b1 || e1 !== 1'b1) begin
          bad++;
          $display("[TB] FAIL div_issue: got rdy=%b e1=%b, want 1 1", in_ready, e1);
        end
      end else if (k < DIV) begin
        total++;
        if (in_ready !== 1'b0 || div_busy !== 1'b1) begin
          bad++;
          $display("[TB] FAIL div_block k=%0d: got rdy=%b busy=%b, want rdy=0 busy=1", k, in_ready, div_busy);
        end
      end else if (k == DIV) begin
        total++;
        if ({in_ready, e1, e2, div_busy} !== 4'b1110) begin
          bad++;
          $display("[TB] FAIL div_handoff: got rdy/e1/e2/busy=%b, want 1110", {in_ready, e1, e2, div_busy});
        end
      end else if (k == DIV + 1) begin
        total++;
        if ({v1, v2, e2, div_busy} !== 4'b1110) begin
          bad++;
          $display("[TB] FAIL div_follow: got v1/v2/e2/busy=%b, want 1110", {v1, v2, e2, div_busy});
        end
      end
      if (out_valid && out_ready) begin
        total++;
        expv = (expQ.size() > 0) ? expQ.pop_front() : -1;
        if (cyc !== expv) begin
          bad++;
          $display("[TB] FAIL sb_div: result at cycle %0d, expected cycle %0d", cyc, expv);
        end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_stall_drain();
    int t0, expv;
    int expOcc[10] = '{0, 1, 2, 3, 3, 3, 3, 2, 1, 0};
    t0 = cyc;
    for (int k = 0; k < 10; k++) begin
      in_valid = (k < 6); in_div = 0; out_ready = (k >= 6);
      if (k < 3) expQ.push_back(t0 + 6 + k);
      @(negedge clock);
      total++;
      if (occ !== 2'(expOcc[k])) begin
        bad++;
        $display("[TB] FAIL stall_occ k=%0d: got %0d, want %0d", k, occ, expOcc[k]);
      end
      if (k >= 3 && k < 6) begin
        total++;
        if (in_ready !== 1'b0 || e1 !== 1'b0 || e3 !== 1'b0) begin
          bad++;
          $display("[TB] FAIL stall_block k=%0d: got rdy/e1/e3=%b, want 000", k, {in_ready, e1, e3});
        end
      end
      if (k == 6) begin
        total++;
        if ({in_ready, e2, e3} !== 3'b111) begin
          bad++;
          $display("[TB] FAIL stall_release: got rdy/e2/e3=%b, want 111", {in_ready, e2, e3});
        end
      end
      if (out_valid && out_ready) begin
        total++;
        expv = (expQ.size() > 0) ? expQ.pop_front() : -1;
        if (cyc !== expv) begin
          bad++;
          $display("[TB] FAIL sb_stall: result at cycle %0d, expected cycle %0d", cyc, expv);
        end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_flush();
    int expv;
    for (int k = 0; k < 8; k++) begin
      in_valid = (k <= 2); in_div = (k == 3); out_ready = 1; flush = (k == 2);
      @(negedge clock);
      if (k == 2) begin
        total++;
        if (occ !== 2'd2 || {in_ready, e1, e2, e3} !== 4'b0) begin
          bad++;
          $display("[TB] FAIL flush_cycle: got occ=%0d rdy/e1/e2/e3=%b, want occ=2 0000",
                   occ, {in_ready, e1, e2, e3});
        end
      end else if (k == 3) begin
        total++;
        if (occ !== 2'd0 || out_valid !== 1'b0) begin
          bad++;
          $display("[TB] FAIL flush_after: got occ=%0d ov=%b, want occ=0 ov=0", occ, out_valid);
        end
      end else if (k > 3) begin
        total++;
        if ({v1, div_busy, out_valid} !== 3'b0) begin
          bad++;
          $display("[TB] FAIL flush_idle k=%0d: got v1/busy/ov=%b, want 000", k, {v1, div_busy, out_valid});
        end
      end
      if (out_valid && out_ready) begin
        total++;
        expv = (expQ.size() > 0) ? expQ.pop_front() : -1;
        if (cyc !== expv) begin
          bad++;
          $display("[TB] FAIL sb_flush: result at cycle %0d, expected cycle %0d", cyc, expv);
        end
      end
      @(posedge clock); #1;
    end
    flush = 0;
  endtask

  task automatic test_clr_mid_div();
    int t0, expv;
    t0 = cyc;
    for (int k = 0; k < 27; k++) begin
      in_valid = (k == 0 || k == 8); in_div = (k == 0 || k == 8); out_ready = 1; clr = (k == 7);
      if (k == 8) expQ.push_back(t0 + 8 + DIV + 2);
      @(negedge clock);
      if (k == 7) begin
        total++;
        if ({in_ready, e1, e2, e3} !== 4'b0) begin
          bad++;
          $display("[TB] FAIL clr_cycle: got rdy/e1/e2/e3=%b, want 0000", {in_ready, e1, e2, e3});
        end
      end else if (k == 8) begin
        total++;
        if ({v1, v2, v3, div_busy, in_ready} !== 5'b00001) begin
          bad++;
          $display("[TB] FAIL clr_after: got v1v2v3/busy/rdy=%b, want 00001", {v1, v2, v3, div_busy, in_ready});
        end
      end else if (k > 8 && k < 8 + DIV) begin
        total++;
        if (div_busy !== 1'b1 || e2 !== 1'b0) begin
          bad++;
          $display("[TB] FAIL clr_newdiv_busy k=%0d: got busy=%b e2=%b, want 1 0", k, div_busy, e2);
        end
      end else if (k == 8 + DIV) begin
        total++;
        if (e2 !== 1'b1 || div_busy !== 1'b0) begin
          bad++;
          $display("[TB] FAIL clr_newdiv_done: got e2=%b busy=%b, want 1 0", e2, div_busy);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        expv = (expQ.size() > 0) ? expQ.pop_front() : -1;
        if (cyc !== expv) begin
          bad++;
          $display("[TB] FAIL sb_clr: result at cycle %0d, expected cycle %0d", cyc, expv);
        end
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single_mul();
    test_back_to_back();
    test_div_then_mul();
    test_stall_drain();
    test_flush();
    test_clr_mid_div();
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL sb_drain: %0d expected results never appeared, want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
